// File: rtl/mac_acc_pkg.sv
// -----------------------------------------------------------------------------
// mac_acc_pkg
// Shared types and helpers for the multi-lane psum accumulator.
//   acc_state_e : pass-tracking FSM states (S_FIRST, S_ACCUM)
//   ptr_width() : pointer width for a circular store of a given depth
//   PTR_W       : pointer width of the default-depth psum buffer
//   lane_sext() : sign-extend the low in_w bits of a lane to LANE_MAX_W bits
//   lane_relu() : clamp a lane of acc_w bits to zero when negative
// Lane helpers work on a LANE_MAX_W-bit container so a single function serves
// every IN_W/ACC_W combination up to 64 bits; callers truncate the result.
// -----------------------------------------------------------------------------
package mac_acc_pkg;

    typedef enum logic [0:0] {
        S_FIRST = 1'b0,
        S_ACCUM = 1'b1
    } acc_state_e;

    localparam int LANE_MAX_W = 64;
    localparam int DEF_DEPTH  = 64;
    localparam int PTR_W      = $clog2(DEF_DEPTH);

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [LANE_MAX_W-1:0] lane_sext(input logic [LANE_MAX_W-1:0] v,
                                                        input int in_w);
        // Move the lane sign bit to the top, then arithmetic-shift it back down.
        return LANE_MAX_W'($signed(v << (LANE_MAX_W - in_w)) >>> (LANE_MAX_W - in_w));
    endfunction

    function automatic logic [LANE_MAX_W-1:0] lane_relu(input logic [LANE_MAX_W-1:0] v,
                                                        input int acc_w);
        logic neg;
        neg = |(v & (LANE_MAX_W'(1) << (acc_w - 1)));
        return neg ? '0 : v;
    endfunction

endpackage

// File: rtl/fifo_no_rst_data.sv
// -----------------------------------------------------------------------------
// fifo_no_rst_data
// Synchronous FIFO whose pointers/occupancy are reset but whose storage is not.
// Push while full and pop while empty are ignored. DEPTH need not be a power
// of two.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-low reset
//   i_push, i_data   write request and data
//   i_pop            read request (head advances)
//   o_data           head entry (undefined while o_empty)
//   o_full, o_empty  occupancy status
// -----------------------------------------------------------------------------
module fifo_no_rst_data
    import mac_acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths stay inside the array.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full  = (count == CW'(DEPTH));
    assign o_empty = (count == '0);
    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;
    assign o_data  = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; occupancy gates every read,
    // so stale contents are never observed and the array maps to plain RAM.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/mac_psum_buf.sv
// -----------------------------------------------------------------------------
// mac_psum_buf
// Circular intermediate-psum buffer (DEPTH x WIDTH) between accumulation
// passes. Push and pop in the same cycle are legal even when full.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-low reset
//   i_push, i_data   append at tail
//   i_pop            drop head
//   i_flush          discard all entries (wins over push/pop)
//   o_data           head entry
//   o_count          occupancy 0..DEPTH
//   o_full, o_empty  occupancy status
// -----------------------------------------------------------------------------
module mac_psum_buf
    import mac_acc_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PW    = PTR_W,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full  = (o_count == CW'(DEPTH));
    assign o_empty = (o_count == '0);
    assign do_pop  = i_pop & ~o_empty;
    // A simultaneous pop frees the slot the push needs.
    assign do_push = i_push & (~o_full | do_pop);
    assign o_data  = mem[head];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            head    <= '0;
            tail    <= '0;
            o_count <= '0;
        end else if (i_flush) begin
            head    <= '0;
            tail    <= '0;
            o_count <= '0;
        end else begin
            if (do_push) tail <= ptr_inc(tail);
            if (do_pop)  head <= ptr_inc(head);
            o_count <= o_count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) mem[tail] <= i_data;
    end

endmodule

// File: rtl/mac_psum_accumulator_mlane.sv
// -----------------------------------------------------------------------------
// mac_psum_accumulator_mlane
// Multi-lane integer partial-sum accumulator. Each accepted beat adds the
// sign-extended psum vector to either the bias (first pass) or the buffered
// intermediate psum (later passes). Non-final results go to the psum buffer,
// final-pass results go to the output FIFO one cycle after acceptance.
// Optional build macro: MAC_PSUM_ACC_RELU_EN clamps negative final-pass lanes
// to zero before they enter the output FIFO.
// Ports:
//   i_clk, i_reset                  clock, asynchronous active-low reset
//   i_bias_enable, i_bias_mode      bias operand select / pop policy
//   i_psum_valid, o_psum_ready      psum beat handshake
//   i_psum_data                     LANES x IN_W signed psums
//   i_inter_end, i_accum_end        last beat of pass / beat is in final pass
//   i_bias_valid, o_bias_ready      bias vector handshake
//   i_bias_data                     LANES x ACC_W signed bias
//   o_output_valid, i_output_ready  result handshake
//   o_output_data, o_output_last    LANES x ACC_W result, end-of-final-pass tag
//   o_err_overflow, o_err_len       sticky error flags
// -----------------------------------------------------------------------------
module mac_psum_accumulator_mlane
    import mac_acc_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int IN_W      = 24,
    parameter int ACC_W     = 32,   // ACC_W >= IN_W, ACC_W <= LANE_MAX_W
    parameter int DEPTH     = DEF_DEPTH,
    parameter int OUT_DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_bias_enable,
    input  logic                   i_bias_mode,
    output logic                   o_psum_ready,
    input  logic                   i_psum_valid,
    input  logic [LANES*IN_W-1:0]  i_psum_data,
    input  logic                   i_inter_end,
    input  logic                   i_accum_end,
    output logic                   o_bias_ready,
    input  logic                   i_bias_valid,
    input  logic [LANES*ACC_W-1:0] i_bias_data,
    input  logic                   i_output_ready,
    output logic                   o_output_valid,
    output logic [LANES*ACC_W-1:0] o_output_data,
    output logic                   o_output_last,
    output logic                   o_err_overflow,
    output logic                   o_err_len
);

    localparam int VW       = LANES * ACC_W;
    localparam int CW       = $clog2(DEPTH + 1);
    localparam int PC_W     = $clog2(DEPTH + 2);
    // Pass-push counter saturates one past DEPTH: any larger count already
    // mismatches every reachable occupancy.
    localparam int PASS_SAT = DEPTH + 1;

    acc_state_e      state_q, state_d;
    logic            active_q;
    logic            accept;
    logic            bias_ok, dest_ok;
    logic            set_ovf, set_len;
    logic            err_ovf_q, err_len_q;

    logic [VW-1:0]   operand_b;
    logic [VW-1:0]   sum_vec;
    logic [VW-1:0]   final_vec;

    logic            bias_pop, bias_full, bias_empty;
    logic [VW-1:0]   bias_head;

    logic            out_push, out_pop, out_full, out_empty;
    logic [VW:0]     out_head;

    logic            buf_push, buf_pop, buf_flush, buf_full, buf_empty;
    logic [CW-1:0]   buf_count;
    logic [VW-1:0]   buf_head;
    logic [CW-1:0]   occ_after;
    logic [PC_W-1:0] pass_pushes_q, pass_pushes_d, pushes_after;

    // Handshakes stay low during reset and for the first cycle after it.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) active_q <= 1'b0;
        else          active_q <= 1'b1;
    end

    // ---------------------------------------------------------------- lanes
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [ACC_W-1:0] psum_ext;
        logic [ACC_W-1:0] sum;

        assign psum_ext = ACC_W'(lane_sext(LANE_MAX_W'(i_psum_data[k*IN_W +: IN_W]), IN_W));
        assign sum      = psum_ext + operand_b[k*ACC_W +: ACC_W];
        assign sum_vec[k*ACC_W +: ACC_W] = sum;
`ifdef MAC_PSUM_ACC_RELU_EN
        assign final_vec[k*ACC_W +: ACC_W] = ACC_W'(lane_relu(LANE_MAX_W'(sum), ACC_W));
`else
        assign final_vec[k*ACC_W +: ACC_W] = sum;
`endif
    end

    // ------------------------------------------------------ control / FSM
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        operand_b     = '0;
        bias_pop      = 1'b0;
        buf_push      = 1'b0;
        buf_pop       = 1'b0;
        buf_flush     = 1'b0;
        out_push      = 1'b0;
        set_ovf       = 1'b0;
        set_len       = 1'b0;

        bias_ok      = (state_q == S_ACCUM) || !i_bias_enable || !bias_empty;
        dest_ok      = !i_accum_end || !out_full;
        o_psum_ready = active_q & bias_ok & dest_ok;
        accept       = i_psum_valid & o_psum_ready;

        case (state_q)
            S_FIRST: begin
                if (i_bias_enable) operand_b = bias_head;
                if (accept) begin
                    // Mode 0 reuses the head for the whole pass.
                    bias_pop = i_bias_enable & (i_bias_mode | i_inter_end);
                    if (i_accum_end)   out_push = 1'b1;
                    else if (buf_full) set_ovf  = 1'b1;   // beat dropped
                    else               buf_push = 1'b1;
                    if (i_inter_end) state_d = i_accum_end ? S_FIRST : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (!buf_empty) operand_b = buf_head;
                if (accept) begin
                    buf_pop = !buf_empty;
                    if (buf_empty) set_len = 1'b1;
                    if (i_accum_end) out_push = 1'b1;
                    else             buf_push = 1'b1;
                    if (i_inter_end) state_d = i_accum_end ? S_FIRST : S_ACCUM;
                end
            end
            default: state_d = S_FIRST;
        endcase

        // A well-formed pass leaves exactly its own pushes in the buffer.
        occ_after    = buf_count + CW'(buf_push) - CW'(buf_pop);
        pushes_after = (pass_pushes_q == PC_W'(PASS_SAT)) ? pass_pushes_q
                                                          : pass_pushes_q + PC_W'(buf_push);
        if (state_q == S_ACCUM && accept && i_inter_end &&
            PC_W'(occ_after) != pushes_after) begin
            set_len   = 1'b1;
            buf_flush = i_accum_end;
        end
        pass_pushes_d = (accept && i_inter_end) ? '0 : pushes_after;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= S_FIRST;
            pass_pushes_q <= '0;
            err_ovf_q     <= 1'b0;
            err_len_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pass_pushes_q <= pass_pushes_d;
            if (set_ovf) err_ovf_q <= 1'b1;
            if (set_len) err_len_q <= 1'b1;
        end
    end

    assign o_err_overflow = err_ovf_q;
    assign o_err_len      = err_len_q;

    // ---------------------------------------------------------- storage
    fifo_no_rst_data #(
        .WIDTH (VW),
        .DEPTH (2)
    ) u_bias_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_bias_valid & o_bias_ready),
        .i_data  (i_bias_data),
        .i_pop   (bias_pop),
        .o_data  (bias_head),
        .o_full  (bias_full),
        .o_empty (bias_empty)
    );

    assign o_bias_ready = active_q & ~bias_full;

    mac_psum_buf #(
        .WIDTH (VW),
        .DEPTH (DEPTH),
        .PW    (ptr_width(DEPTH)),
        .CW    (CW)
    ) u_psum_buf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (buf_push),
        .i_data  (sum_vec),
        .i_pop   (buf_pop),
        .i_flush (buf_flush),
        .o_data  (buf_head),
        .o_count (buf_count),
        .o_full  (buf_full),
        .o_empty (buf_empty)
    );

    fifo_no_rst_data #(
        .WIDTH (VW + 1),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (out_push),
        .i_data  ({i_inter_end, final_vec}),
        .i_pop   (out_pop),
        .o_data  (out_head),
        .o_full  (out_full),
        .o_empty (out_empty)
    );

    assign out_pop        = i_output_ready & ~out_empty;
    assign o_output_valid = ~out_empty;
    // Unreset storage is masked so the outputs read zero whenever idle.
    assign o_output_data  = out_empty ? '0 : out_head[VW-1:0];
    assign o_output_last  = ~out_empty & out_head[VW];

endmodule

// File: tb/tb_mac_psum_accumulator_mlane.sv
module tb_mac_psum_accumulator_mlane;

    localparam int LANES     = 4;
    localparam int IN_W      = 24;
    localparam int ACC_W     = 32;
    localparam int DEPTH     = 8;
    localparam int OUT_DEPTH = 4;
    localparam int DW        = LANES * ACC_W;
    localparam int PW_IN     = LANES * IN_W;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_bias_enable, i_bias_mode;
    logic             o_psum_ready, i_psum_valid;
    logic [PW_IN-1:0] i_psum_data;
    logic             i_inter_end, i_accum_end;
    logic             o_bias_ready, i_bias_valid;
    logic [DW-1:0]    i_bias_data;
    logic             i_output_ready, o_output_valid;
    logic [DW-1:0]    o_output_data;
    logic             o_output_last, o_err_overflow, o_err_len;

    mac_psum_accumulator_mlane #(
        .LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_bias_enable  (i_bias_enable),
        .i_bias_mode    (i_bias_mode),
        .o_psum_ready   (o_psum_ready),
        .i_psum_valid   (i_psum_valid),
        .i_psum_data    (i_psum_data),
        .i_inter_end    (i_inter_end),
        .i_accum_end    (i_accum_end),
        .o_bias_ready   (o_bias_ready),
        .i_bias_valid   (i_bias_valid),
        .i_bias_data    (i_bias_data),
        .i_output_ready (i_output_ready),
        .o_output_valid (o_output_valid),
        .o_output_data  (o_output_data),
        .o_output_last  (o_output_last),
        .o_err_overflow (o_err_overflow),
        .o_err_len      (o_err_len)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PW_IN-1:0] pk_in(input int a, input int b, input int c, input int d);
        return {24'(d), 24'(c), 24'(b), 24'(a)};
    endfunction

    function automatic logic [DW-1:0] pk_acc(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    task automatic expect_out(input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever a result transfers.
    always @(negedge i_clk) begin
        if (i_reset && o_output_valid && i_output_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %h last %0b expected none",
                         o_output_data, o_output_last);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_data", o_output_data, e.data);
                check("out_last", DW'(o_output_last), DW'(e.last));
            end
        end
    end

    task automatic send_beat(input logic [PW_IN-1:0] p, input logic ie, input logic ae);
        bit ok;
        ok = 1'b0;
        i_psum_valid = 1'b1;
        i_psum_data  = p;
        i_inter_end  = ie;
        i_accum_end  = ae;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge i_clk);
            ok = o_psum_ready;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL psum_accept_timeout: got ready=0 expected ready=1 within 200 cycles");
        end else begin
            @(posedge i_clk);
            #1;
        end
        i_psum_valid = 1'b0;
    endtask

    task automatic push_bias(input logic [DW-1:0] b);
        bit ok;
        ok = 1'b0;
        i_bias_valid = 1'b1;
        i_bias_data  = b;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge i_clk);
            ok = o_bias_ready;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL bias_accept_timeout: got ready=0 expected ready=1 within 200 cycles");
        end else begin
            @(posedge i_clk);
            #1;
        end
        i_bias_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge i_clk);
            done = (sb_q.size() == 0) && !o_output_valid;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int low_cnt;
        i_reset        = 1'b0;
        i_bias_enable  = 1'b1;
        i_bias_mode    = 1'b1;
        i_psum_valid   = 1'b0;
        i_psum_data    = '0;
        i_inter_end    = 1'b0;
        i_accum_end    = 1'b0;
        i_bias_valid   = 1'b0;
        i_bias_data    = '0;
        i_output_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_valid",    DW'(o_output_valid), '0);
        check("rst_data",     o_output_data, '0);
        check("rst_last",     DW'(o_output_last), '0);
        check("rst_err_ovf",  DW'(o_err_overflow), '0);
        check("rst_err_len",  DW'(o_err_len), '0);
        check("rst_psum_rdy", DW'(o_psum_ready), '0);
        check("rst_bias_rdy", DW'(o_bias_ready), '0);
        @(posedge i_clk);
        #1 i_reset = 1'b1;
        @(posedge i_clk);
        #1;

        // Single pass, bias mode 1
        push_bias(pk_acc(10, 20, 30, 40));
        check("t1_idle_valid", DW'(o_output_valid), '0);
        expect_out(pk_acc(11, 22, 33, 44), 1'b1);
        send_beat(pk_in(1, 2, 3, 4), 1'b1, 1'b1);
        check("t1_valid_latency", DW'(o_output_valid), DW'(1));
        check("t1_last_latency",  DW'(o_output_last), DW'(1));
        i_output_ready = 1'b1;
        wait_drain();

        // Three passes of three beats, bias mode 0
        i_bias_mode = 1'b0;
        push_bias(pk_acc(100, 0, 0, 0));
        push_bias(pk_acc(500, 0, 0, 0));
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 3; b++) begin
                if (p == 2) expect_out(pk_acc(103, 0, 0, 0), b == 2);
                send_beat(pk_in(1, 0, 0, 0), b == 2, p == 2);
            end
        end
        wait_drain();
        check("t2_one_bias_pop", DW'(o_bias_ready), DW'(1));
        expect_out(pk_acc(505, 0, 0, 0), 1'b1);
        send_beat(pk_in(5, 0, 0, 0), 1'b1, 1'b1);
        wait_drain();

        // Two's-complement wrap and sign extension
        i_bias_mode = 1'b1;
        push_bias(pk_acc(32'h7FFF_FFFF, -1, 0, 10));
`ifdef MAC_PSUM_ACC_RELU_EN
        expect_out(pk_acc(0, 0, 0, 3), 1'b1);
`else
        expect_out(pk_acc(32'h8000_0000, 0, -1, 3), 1'b1);
`endif
        send_beat(pk_in(1, 1, -1, -7), 1'b1, 1'b1);
        wait_drain();

        // Bias disabled: zero operand, FIFO untouched
        i_bias_enable = 1'b0;
`ifdef MAC_PSUM_ACC_RELU_EN
        expect_out(pk_acc(7, 0, 0, 1), 1'b1);
`else
        expect_out(pk_acc(7, -8, 0, 1), 1'b1);
`endif
        send_beat(pk_in(7, -8, 0, 1), 1'b1, 1'b1);
        wait_drain();

        // Backpressure during the final pass
        i_output_ready = 1'b0;
        for (int i = 1; i <= OUT_DEPTH; i++) begin
            expect_out(pk_acc(i, 0, 0, 0), 1'b0);
            send_beat(pk_in(i, 0, 0, 0), 1'b0, 1'b1);
        end
        i_psum_valid = 1'b1;
        i_psum_data  = pk_in(5, 0, 0, 0);
        i_inter_end  = 1'b0;
        i_accum_end  = 1'b1;
        low_cnt = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (!o_psum_ready) low_cnt++;
        end
        check("t6_ready_low_10", DW'(low_cnt), DW'(10));
        @(posedge i_clk);
        #1 i_output_ready = 1'b1;
        expect_out(pk_acc(5, 0, 0, 0), 1'b0);
        send_beat(pk_in(5, 0, 0, 0), 1'b0, 1'b1);
        expect_out(pk_acc(6, 0, 0, 0), 1'b1);
        send_beat(pk_in(6, 0, 0, 0), 1'b1, 1'b1);
        wait_drain();

        // Overflow: first pass of DEPTH+1 beats
        for (int i = 0; i <= DEPTH; i++) send_beat(pk_in(i, 0, 0, 0), i == DEPTH, 1'b0);
        check("t7_err_ovf", DW'(o_err_overflow), DW'(1));
        check("t7_no_len",  DW'(o_err_len), '0);

        // Length: second pass one beat longer
        for (int i = 0; i <= DEPTH; i++) send_beat(pk_in(0, 0, 0, 0), i == DEPTH, 1'b0);
        check("t7_err_len", DW'(o_err_len), DW'(1));

        // Mid-stream reset with a beat pending
        i_psum_valid = 1'b1;
        i_psum_data  = pk_in(9, 9, 9, 9);
        i_inter_end  = 1'b0;
        i_accum_end  = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        check("mrst_err_ovf",  DW'(o_err_overflow), '0);
        check("mrst_err_len",  DW'(o_err_len), '0);
        check("mrst_valid",    DW'(o_output_valid), '0);
        check("mrst_psum_rdy", DW'(o_psum_ready), '0);
        check("mrst_bias_rdy", DW'(o_bias_ready), '0);
        i_psum_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;
        @(posedge i_clk);
        #1;

        // FSM back in S_FIRST, buffer empty: clean two-pass run
        send_beat(pk_in(3, 0, 0, 0), 1'b1, 1'b0);
        expect_out(pk_acc(7, 0, 0, 0), 1'b1);
        send_beat(pk_in(4, 0, 0, 0), 1'b1, 1'b1);
        wait_drain();
        check("post_err_ovf", DW'(o_err_overflow), '0);
        check("post_err_len", DW'(o_err_len), '0);
        check("sb_empty", DW'(sb_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
